// File: rtl/viterbi_frame_ctrl_if.sv
// Bundle of the frame controller's handshake and bus signals.
// master: the frame controller. slave: ACS unit, survivor memory, trace_back and consumer.
interface viterbi_frame_ctrl_if #(
    parameter int unsigned AW = 6
);
    // Frame request and ACS survivor stream
    logic          start;
    logic          acs_valid;
    logic [7:0]    acs_survivor;
    logic [2:0]    best_state;
    logic          acs_ready;

    // Survivor memory write port
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    // trace_back control and decoded bit
    logic          tb_clr_n;
    logic          tb_enable;
    logic [2:0]    tb_start_idx;
    logic          tb_bit;

    // Decoded output stream
    logic          out_valid;
    logic          out_bit;
    logic          out_last;
    logic          out_ready;

    // Status
    logic          busy;
    logic          frame_done;
    logic          overrun;

    modport master (
        input  start, acs_valid, acs_survivor, best_state, tb_bit, out_ready,
        output acs_ready, mem_we, mem_waddr, mem_wdata, tb_clr_n, tb_enable, tb_start_idx,
               out_valid, out_bit, out_last, busy, frame_done, overrun
    );

    modport slave (
        output start, acs_valid, acs_survivor, best_state, tb_bit, out_ready,
        input  acs_ready, mem_we, mem_waddr, mem_wdata, tb_clr_n, tb_enable, tb_start_idx,
               out_valid, out_bit, out_last, busy, frame_done, overrun
    );
endinterface

// File: rtl/viterbi_frame_ctrl.sv
// Viterbi back-end frame controller: fills the survivor memory from the ACS unit, runs
// trace_back over the stored frame and returns the decoded bits.
// Optional feature macro: VITERBI_FRAME_CTRL_LIFO_EN
//   defined   - DEPTHx1 LIFO plus DRAIN state; output in forward time order with out_ready
//               backpressure.
//   undefined - decoded bits stream straight out during TRACE in reverse time order;
//               out_ready is ignored.
// DEPTH must equal 2**AW.
module viterbi_frame_ctrl #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input logic                 clk,
    input logic                 rst,
    viterbi_frame_ctrl_if.master bus
);

    localparam logic [AW-1:0] LastIdx = AW'(DEPTH - 1);

`ifdef VITERBI_FRAME_CTRL_LIFO_EN
    typedef enum logic [1:0] {StIdle, StFill, StTrace, StDrain} state_e;
`else
    typedef enum logic [1:0] {StIdle, StFill, StTrace} state_e;
`endif

    state_e        state_q;
    // Write address in FILL; reused as the tb_enable cycle counter in TRACE.
    logic [AW-1:0] wcnt_q;
    // Capture counter in TRACE; doubles as the LIFO pointer in DRAIN.
    logic [AW-1:0] cap_cnt_q;
    logic [2:0]    best_q;
    logic          mem_we_q;
    logic [AW-1:0] mem_waddr_q;
    logic [7:0]    mem_wdata_q;
    logic          tb_clr_n_q;
    logic          tb_enable_q;
    logic          cap_q;
    logic          frame_done_q;
    logic          overrun_q;
    logic          acs_ready;

`ifdef VITERBI_FRAME_CTRL_LIFO_EN
    logic             out_valid_q;
    logic             out_bit_q;
    logic             out_last_q;
    logic [DEPTH-1:0] lifo_q;
`endif

    assign acs_ready = (state_q == StFill);

    // Frame sequencer with registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            wcnt_q       <= '0;
            cap_cnt_q    <= '0;
            best_q       <= '0;
            mem_we_q     <= 1'b0;
            mem_waddr_q  <= '0;
            mem_wdata_q  <= '0;
            tb_clr_n_q   <= 1'b1;
            tb_enable_q  <= 1'b0;
            cap_q        <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef VITERBI_FRAME_CTRL_LIFO_EN
            out_valid_q  <= 1'b0;
            out_bit_q    <= 1'b0;
            out_last_q   <= 1'b0;
`endif
        end else begin
            mem_we_q     <= 1'b0;
            tb_clr_n_q   <= 1'b1;
            frame_done_q <= 1'b0;
            cap_q        <= tb_enable_q;

            // A survivor word offered while not ready is dropped and flagged for good.
            if (bus.acs_valid && !acs_ready) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q    <= StFill;
                        tb_clr_n_q <= 1'b0;
                        wcnt_q     <= '0;
                    end
                end

                StFill: begin
                    if (bus.acs_valid) begin
                        mem_we_q    <= 1'b1;
                        mem_waddr_q <= wcnt_q;
                        mem_wdata_q <= bus.acs_survivor;
                        wcnt_q      <= wcnt_q + 1'b1;
                        // Last word: wcnt wraps to 0 and trace-back starts next cycle.
                        if (wcnt_q == LastIdx) begin
                            best_q      <= bus.best_state;
                            state_q     <= StTrace;
                            tb_enable_q <= 1'b1;
                            cap_cnt_q   <= '0;
                        end
                    end
                end

                StTrace: begin
                    if (tb_enable_q) begin
                        wcnt_q <= wcnt_q + 1'b1;
                        if (wcnt_q == LastIdx) begin
                            tb_enable_q <= 1'b0;
                        end
                    end
                    if (cap_q) begin
                        if (cap_cnt_q == LastIdx) begin
`ifdef VITERBI_FRAME_CTRL_LIFO_EN
                            // Newest bit is the LIFO head: present it directly.
                            state_q     <= StDrain;
                            out_valid_q <= 1'b1;
                            out_bit_q   <= bus.tb_bit;
                            out_last_q  <= 1'b0;
`else
                            state_q      <= StIdle;
                            frame_done_q <= 1'b1;
                            cap_cnt_q    <= '0;
`endif
                        end else begin
                            cap_cnt_q <= cap_cnt_q + 1'b1;
                        end
                    end
                end

`ifdef VITERBI_FRAME_CTRL_LIFO_EN
                StDrain: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            state_q      <= StIdle;
                            out_valid_q  <= 1'b0;
                            out_bit_q    <= 1'b0;
                            out_last_q   <= 1'b0;
                            frame_done_q <= 1'b1;
                        end else begin
                            // Pop: entries below the head are lifo_q[cap_cnt_q-1 .. 0].
                            out_bit_q  <= lifo_q[cap_cnt_q - 1'b1];
                            cap_cnt_q  <= cap_cnt_q - 1'b1;
                            out_last_q <= (cap_cnt_q == AW'(1));
                        end
                    end
                end
`endif

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef VITERBI_FRAME_CTRL_LIFO_EN
    // LIFO storage: push each captured bit at the capture counter
    always_ff @(posedge clk) begin
        if (state_q == StTrace && cap_q) begin
            lifo_q[cap_cnt_q] <= bus.tb_bit;
        end
    end
`endif

    assign bus.acs_ready    = acs_ready;
    assign bus.busy         = (state_q != StIdle);
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_waddr    = mem_waddr_q;
    assign bus.mem_wdata    = mem_wdata_q;
    assign bus.tb_clr_n     = tb_clr_n_q;
    assign bus.tb_enable    = tb_enable_q;
    assign bus.tb_start_idx = best_q;
    assign bus.frame_done   = frame_done_q;
    assign bus.overrun      = overrun_q;

`ifdef VITERBI_FRAME_CTRL_LIFO_EN
    assign bus.out_valid = out_valid_q;
    assign bus.out_bit   = out_bit_q;
    assign bus.out_last  = out_last_q;
`else
    // Captured bits leave as they arrive, in reverse time order.
    assign bus.out_valid = cap_q;
    assign bus.out_bit   = cap_q & bus.tb_bit;
    assign bus.out_last  = cap_q && (cap_cnt_q == LastIdx);
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed self-checking bench for viterbi_frame_ctrl (either build of
// VITERBI_FRAME_CTRL_LIFO_EN). A small trace_back model returns pat[k] on capture k.
module tb_viterbi_frame_ctrl;

    localparam int unsigned AW = 6;
`ifdef VITERBI_FRAME_CTRL_LIFO_EN
    localparam bit LIFO = 1'b1;
    localparam int LAT  = 130;
`else
    localparam bit LIFO = 1'b0;
    localparam int LAT  = 66;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viterbi_frame_ctrl_if #(.AW(AW)) bus ();

    viterbi_frame_ctrl #(.DEPTH(64), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [63:0]   pat;
    logic [2:0]    exp_idx;
    logic [AW-1:0] waddr_log [64];
    logic [7:0]    wdata_log [64];
    logic          out_log   [64];
    logic          last_log  [64];
    int wr_cnt, en_cnt, en_first, en_last, idx_bad, clr_low, hs_cnt, done_cnt, done_cyc;
    int acs_cyc, stab_bad;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // trace_back model: the bit for capture k appears the cycle after the k-th enable
    initial begin
        bit prev_en;
        int idx;
        prev_en    = 1'b0;
        idx        = 0;
        bus.tb_bit = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst || bus.tb_clr_n === 1'b0) begin
                idx        = 0;
                prev_en    = 1'b0;
                bus.tb_bit = 1'b0;
            end else begin
                if (prev_en && idx < 64) begin
                    bus.tb_bit = pat[idx];
                    idx++;
                end else begin
                    bus.tb_bit = 1'b0;
                end
                prev_en = bus.tb_enable;
            end
        end
    end

    // Monitor: samples on the falling edge
    initial begin
        bit hs, prev_stall, prev_bit, prev_last;
        prev_stall = 1'b0;
        prev_bit   = 1'b0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_we === 1'b1) begin
                if (wr_cnt < 64) begin
                    waddr_log[wr_cnt] = bus.mem_waddr;
                    wdata_log[wr_cnt] = bus.mem_wdata;
                end
                wr_cnt++;
            end
            if (bus.acs_valid && bus.acs_ready) acs_cyc = cyc;
            if (bus.tb_enable === 1'b1) begin
                if (en_cnt == 0) en_first = cyc;
                en_last = cyc;
                en_cnt++;
                if (bus.tb_start_idx !== exp_idx) idx_bad++;
            end
            if (bus.tb_clr_n === 1'b0) clr_low++;
            hs = (bus.out_valid === 1'b1) && (!LIFO || bus.out_ready === 1'b1);
            if (hs) begin
                if (hs_cnt < 64) begin
                    out_log[hs_cnt]  = bus.out_bit;
                    last_log[hs_cnt] = bus.out_last;
                end
                hs_cnt++;
            end
            if (LIFO && prev_stall && bus.out_valid === 1'b1 &&
                (bus.out_bit !== prev_bit || bus.out_last !== prev_last)) stab_bad++;
            prev_stall = (bus.out_valid === 1'b1) && (bus.out_ready !== 1'b1);
            prev_bit   = bus.out_bit;
            prev_last  = bus.out_last;
            if (bus.frame_done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required normal end");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_cnt = 0; en_cnt = 0; en_first = 0; en_last = 0; idx_bad = 0; clr_low = 0;
        hs_cnt = 0; done_cnt = 0; done_cyc = 0; acs_cyc = 0; stab_bad = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.start = 1'b0; bus.acs_valid = 1'b0; bus.acs_survivor = 8'h00;
        bus.best_state = 3'd0; bus.out_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic send_frame(input int n, input bit gaps, input logic [2:0] best);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.acs_valid    = 1'b1;
            bus.acs_survivor = 8'(8'hA5 + i);
            bus.best_state   = (i == 63) ? best : 3'd0;
            tick();
            if (gaps) begin
                bus.acs_valid    = 1'b0;
                bus.acs_survivor = 8'h00;
                bus.best_state   = 3'd0;
                tick();
            end
        end
        bus.acs_valid  = 1'b0;
        bus.best_state = 3'd0;
    endtask

    task automatic wait_done(input bit bp);
        int base;
        bit got;
        base = done_cnt;
        got  = 1'b0;
        for (int i = 0; i < 2000 && !got; i++) begin
            bus.out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (done_cnt != base) got = 1'b1;
        end
        bus.out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL frame_done_timeout: got %0d pulses, required 1", done_cnt - base);
        end
    endtask

    // Checks the decoded stream against pat in the order the build must produce
    task automatic check_stream(input string tag);
        logic exp_bit, exp_last;
        checks++;
        if (hs_cnt !== 64) begin
            errors++;
            $display("FAIL %s_handshakes: got %0d, required 64", tag, hs_cnt);
        end
        for (int j = 0; j < 64; j++) begin
            exp_bit  = LIFO ? pat[63 - j] : pat[j];
            exp_last = (j == 63);
            checks++;
            if (out_log[j] !== exp_bit || last_log[j] !== exp_last) begin
                errors++;
                $display("FAIL %s_bit%0d: got bit=%b last=%b, required bit=%b last=%b",
                         tag, j, out_log[j], last_log[j], exp_bit, exp_last);
            end
        end
        checks++;
        if (done_cnt !== 1) begin
            errors++;
            $display("FAIL %s_done_count: got %0d, required 1", tag, done_cnt);
        end
    endtask

    task automatic test_reset();
        logic [26:0] outs, exp_outs;
        exp_outs = {1'b0, 1'b0, 6'd0, 8'd0, 1'b1, 1'b0, 3'd0, 6'd0};
        do_reset();
        outs = {bus.acs_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.tb_clr_n,
                bus.tb_enable, bus.tb_start_idx, bus.out_valid, bus.out_bit, bus.out_last,
                bus.busy, bus.frame_done, bus.overrun};
        checks++;
        if (outs !== exp_outs) begin
            errors++;
            $display("FAIL reset_values: got %h, required %h", outs, exp_outs);
        end
        // Reset in the middle of FILL with wcnt at 20
        pat = '0;
        send_frame(20, 1'b0, 3'd0);
        checks++;
        if (bus.busy !== 1'b1 || bus.mem_we !== 1'b1) begin
            errors++;
            $display("FAIL midfill_busy: got busy=%b we=%b, required 1 1", bus.busy, bus.mem_we);
        end
        #2;
        rst = 1'b0;
        #1;
        outs = {bus.acs_ready, bus.mem_we, bus.mem_waddr, bus.mem_wdata, bus.tb_clr_n,
                bus.tb_enable, bus.tb_start_idx, bus.out_valid, bus.out_bit, bus.out_last,
                bus.busy, bus.frame_done, bus.overrun};
        checks++;
        if (outs !== exp_outs) begin
            errors++;
            $display("FAIL async_reset_values: got %h, required %h", outs, exp_outs);
        end
        #2;
        rst = 1'b1;
        tick();
        clear_mon();
        send_frame(2, 1'b0, 3'd0);
        repeat (3) tick();
        checks++;
        if (wr_cnt !== 2 || waddr_log[0] !== 6'd0 || waddr_log[1] !== 6'd1) begin
            errors++;
            $display("FAIL restart_addr: got n=%0d a0=%0d a1=%0d, required n=2 a0=0 a1=1",
                     wr_cnt, waddr_log[0], waddr_log[1]);
        end
        checks++;
        if (clr_low !== 1) begin
            errors++;
            $display("FAIL restart_clr_pulse: got %0d low cycles, required 1", clr_low);
        end
        do_reset();
    endtask

    task automatic test_fill_gaps();
        for (int k = 0; k < 64; k++) pat[k] = (k % 3 == 0);
        exp_idx = 3'd5;
        clear_mon();
        send_frame(64, 1'b1, 3'd5);
        wait_done(1'b0);
        checks++;
        if (wr_cnt !== 64) begin
            errors++;
            $display("FAIL fill_write_count: got %0d, required 64", wr_cnt);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (waddr_log[i] !== 6'(i) || wdata_log[i] !== 8'(8'hA5 + i)) begin
                errors++;
                $display("FAIL fill_write%0d: got addr=%0d data=%h, required addr=%0d data=%h",
                         i, waddr_log[i], wdata_log[i], i, 8'(8'hA5 + i));
            end
        end
        checks++;
        if (en_cnt !== 64 || en_last - en_first + 1 !== 64) begin
            errors++;
            $display("FAIL fill_enable_span: got count=%0d span=%0d, required 64 64",
                     en_cnt, en_last - en_first + 1);
        end
        checks++;
        if (en_first !== acs_cyc + 1) begin
            errors++;
            $display("FAIL fill_enable_start: got cycle %0d, required %0d", en_first, acs_cyc + 1);
        end
        checks++;
        if (idx_bad !== 0) begin
            errors++;
            $display("FAIL fill_start_idx: got %0d bad cycles, required 0", idx_bad);
        end
        checks++;
        if (bus.busy !== 1'b0 || bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL fill_end_state: got busy=%b overrun=%b, required 0 0",
                     bus.busy, bus.overrun);
        end
    endtask

    task automatic test_order();
        // Symmetric pattern from the plan, then an asymmetric one that exposes order errors
        for (int r = 0; r < 2; r++) begin
            if (r == 0) begin
                for (int k = 0; k < 64; k++) pat[k] = (k % 3 == 0);
            end else begin
                pat = 64'h0123_4567_89AB_CDEF;
            end
            exp_idx = 3'd2;
            clear_mon();
            send_frame(64, 1'b0, 3'd2);
            wait_done(1'b0);
            check_stream(r == 0 ? "order_mod3" : "order_asym");
            checks++;
            if (done_cyc - acs_cyc !== LAT) begin
                errors++;
                $display("FAIL order_latency: got %0d cycles, required %0d",
                         done_cyc - acs_cyc, LAT);
            end
        end
    endtask

    task automatic test_backpressure();
        pat     = 64'hF0E1_D2C3_B4A5_9687;
        exp_idx = 3'd7;
        clear_mon();
        send_frame(64, 1'b0, 3'd7);
        wait_done(1'b1);
        check_stream("bp");
        checks++;
        if (stab_bad !== 0) begin
            errors++;
            $display("FAIL bp_stability: got %0d unstable stalls, required 0", stab_bad);
        end
    endtask

    task automatic test_overrun();
        pat     = 64'h8000_0000_0000_0003;
        exp_idx = 3'd3;
        clear_mon();
        send_frame(64, 1'b0, 3'd3);
        tick();
        bus.acs_valid    = 1'b1;
        bus.acs_survivor = 8'h3C;
        bus.start        = 1'b1;
        repeat (3) tick();
        bus.acs_valid = 1'b0;
        bus.start     = 1'b0;
        checks++;
        if (bus.overrun !== 1'b1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL overrun_set: got overrun=%b busy=%b, required 1 1",
                     bus.overrun, bus.busy);
        end
        wait_done(1'b0);
        check_stream("ovr");
        checks++;
        if (wr_cnt !== 64 || clr_low !== 1 || idx_bad !== 0) begin
            errors++;
            $display("FAIL overrun_side_effects: got writes=%0d clr=%0d idxbad=%0d, required 64 1 0",
                     wr_cnt, clr_low, idx_bad);
        end
        repeat (4) tick();
        checks++;
        if (bus.overrun !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL overrun_sticky: got overrun=%b busy=%b, required 1 0",
                     bus.overrun, bus.busy);
        end
        do_reset();
        checks++;
        if (bus.overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b, required 0", bus.overrun);
        end
    endtask

    initial begin
        pat     = '0;
        exp_idx = 3'd0;
        clear_mon();
        test_reset();
        test_fill_gaps();
        test_order();
        test_backpressure();
        test_overrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/viterbi_frame_ctrl.md
# viterbi_frame_ctrl

Frame controller for the Viterbi decoder back end. It sequences each frame through three steps: it fills the survivor memory from the ACS unit, runs the trace-back unit over the stored frame, and returns the decoded bits to the consumer. It sits between the ACS/min-state finder, the 64×8 survivor memory and the `trace_back` unit.

## Interface
- `DEPTH`, 64: survivor words per frame; must equal 2^AW.
- `AW`, 6: survivor memory address width.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous reset, active-low.
- `start`  in  1: begins a frame when the block is in IDLE; ignored in every other state.
- `acs_valid`  in  1: a survivor word is presented.
- `acs_survivor`  in  8: survivor decision bits, one bit per state.
- `best_state`  in  3: trace-back start state; sampled with the final survivor word.
- `acs_ready`  out  1: high in FILL only.
- `mem_we`  out  1: survivor memory write strobe.
- `mem_waddr`  out  AW: write address.
- `mem_wdata`  out  8: write data.
- `tb_clr_n`  out  1: active-low clear to `trace_back`; low for exactly one cycle.
- `tb_enable`  out  1: `trace_enable` to `trace_back`.
- `tb_start_idx`  out  3: `idx_out` to `trace_back`.
- `tb_bit`  in  1: `decoded_bit` from `trace_back`.
- `out_valid`, `out_bit`, `out_last`  out  1 each: decoded output stream.
- `out_ready`  in  1: consumer accepts the output.
- `busy`  out  1: high whenever the state is not IDLE.
- `frame_done`  out  1: one-cycle pulse when a frame completes.
- `overrun`  out  1: sticky error flag; set when `acs_valid` is high while `acs_ready` is low. Cleared only by `rst`.

## Operation
- States: IDLE, FILL, TRACE, DRAIN. DRAIN exists only when the macro in Configuration is defined.
- **Reset values:**
  - State is IDLE.
  - Every output is 0 except `tb_clr_n`, which is 1.
  - All counters and the LIFO pointer are 0.
- **IDLE:** `start` moves the state to FILL and drives `tb_clr_n` low for that one transition cycle.
- **FILL:**
  - `acs_ready` is 1.
  - Each cycle with `acs_valid` high: `mem_we` is 1, `mem_waddr` equals `wcnt`, `mem_wdata` equals `acs_survivor`, and `wcnt` increments.
  - On the write at `wcnt`=DEPTH-1: latch `best_state`, clear `wcnt` (the counter wraps to 0), go to TRACE.
  - Gaps in `acs_valid` are allowed.
- **TRACE:**
  - `tb_enable` is 1 for exactly DEPTH consecutive cycles, and `tb_start_idx` holds the latched state throughout.
  - `cap` is `tb_enable` delayed by one cycle. Each cycle with `cap` high captures `tb_bit`.
  - Bits are captured in reverse time order (frame bit DEPTH-1 first).
  - After the DEPTH-th capture: go to DRAIN when the macro is defined, otherwise go to IDLE.
- **DRAIN:**
  - Output pops the LIFO, so bits leave in forward time order.
  - `out_valid` is 1. A pop happens on `out_valid && out_ready`.
  - `out_last` is 1 on the DEPTH-th bit.
  - After the last handshake: go to IDLE and pulse `frame_done`.
- **Output stability:** `out_bit` and `out_last` are held stable while `out_valid && !out_ready`.
- **Simultaneous events:**
  - `start` while `busy` is ignored.
  - `acs_valid` outside FILL is dropped and sets `overrun`; the memory is not written.
- **Reset mid-frame:** everything returns to reset values immediately (asynchronously). No partial frame is resumed. The next `start` re-clears `trace_back` through `tb_clr_n`.

## Timing
- `mem_we`, `mem_waddr` and `mem_wdata` are registered: the write lands one cycle after the `acs_valid` cycle.
- **Capture alignment:** the first `tb_enable` is in cycle T0 and the first capture is in cycle T0+1. TRACE lasts DEPTH+1 cycles.
- **Throughput:** 1 bit per cycle in both the non-LIFO stream and DRAIN.
- **Frame latency**, measured from the final survivor write to `frame_done`:
  - Macro defined, `out_ready` held high: 2·DEPTH+2 cycles.
  - Macro undefined: DEPTH+2 cycles.

## Configuration
- Macro: `VITERBI_FRAME_CTRL_LIFO_EN`.
- **Defined:**
  - A DEPTH×1 LIFO is compiled in, together with the DRAIN state.
  - Output is in forward time order with full `out_ready` backpressure.
- **Undefined:**
  - No LIFO and no DRAIN state.
  - `out_valid` equals `cap` during TRACE and `out_bit` equals `tb_bit`, in reverse time order.
  - `out_ready` is ignored; the consumer must accept every cycle.
  - `out_last` marks the DEPTH-th capture, and `frame_done` pulses in the cycle after it.

## Test plan
- Reset check: assert `rst`=0 mid-FILL at `wcnt`=20 → all outputs are at reset values and the state is IDLE. After `start`, writes restart at `mem_waddr`=0 and `tb_clr_n` pulses low for 1 cycle.
- Fill with gaps: feed 64 words of value `8'hA5+i` with `acs_valid` toggling 1/0, and `best_state`=5 on the last word → addresses 0..63 are written in order, and `tb_enable` is high for exactly 64 cycles with `tb_start_idx`=5.
- LIFO order (macro defined): drive `tb_bit` during capture as pattern p[k] = k mod 3 == 0 → `out_bit` sequence is p[63]..p[0], `out_last` on the 64th bit, and `frame_done` pulses once.
- Backpressure (macro defined): toggle `out_ready` randomly → no bit is lost or duplicated, `out_bit` is stable while stalled, and exactly 64 handshakes occur.
- Non-LIFO build: same stimulus as the LIFO-order test → the output equals p[0]..p[63] in capture order, and `frame_done` arrives 66 cycles after the last write.
- Overrun: assert `acs_valid` during TRACE, and assert `start` during TRACE → `overrun`=1 and stays set, no `mem_we` is issued, and the frame completes unaffected.
